issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- In-order issue stage between instruction fetch/predecode and the decode-execute-writeback pipe.
- Tracks in-flight register writes in the add and mult pipes and holds an instruction, inserting a NOP bubble, on a RAW hazard, a write-order hazard or a writeback-port collision.
- Drives the fetch enable and a registered instruction bundle that feeds the execute stage directly.

Parameters:
ADD_LAT, 4, edges from the execute stage capturing an ADD/ADDI to its result appearing at the writeback port
MUL_LAT, 4, same for MUL
CNT_W, 16, width of the stall performance counter

Ports:
clock  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
run  input  1  global advance enable; drives execute start
in_valid  input  1  predecoded instruction present
in_opcode  input  3  predecoded opcode
in_rs1  input  5  source 1
in_rs2  input  5  source 2
in_rd  input  5  destination
in_imm  input  12  immediate, passed through unchanged
fetch_en  output  1  fetch advance (start of fetch stage)
out_opcode  output  3  issued opcode, registered
out_rs1  output  5  issued rs1, registered
out_rs2  output  5  issued rs2, registered
out_rd  output  5  issued rd, registered
out_imm  output  12  issued imm, registered
stall  output  1  hazard detected this cycle, combinational
stall_cnt  output  CNT_W  count of bubble cycles, saturating

Behaviour:
- Reset: rst is asynchronous, active-low, clock is clock. While rst=0, all out_* are 0 (NOP to R0), every scoreboard counter is 0, the WB reservation vector is 0 and stall_cnt is 0. fetch_en=0 during reset. Reset mid-stall discards the held instruction state; fetch re-supplies it.
- Class decode on in_opcode[1:0]; bit 2 is passed through and otherwise ignored:
  - 00 NOP: no reads, no write.
  - 01 ADD: reads rs1 and rs2; latency L=ADD_LAT.
  - 10 MUL: reads rs1 and rs2; latency L=MUL_LAT.
  - 11 ADDI: reads rs1 only, because the rs2 bits overlap imm; latency L=ADD_LAT.
- in_valid=0 is treated as NOP.
- R0 rule: rd=0 is no write and creates no scoreboard entry. A source equal to 0 never hazards.
- Scoreboard: one counter per register, wide enough for max(ADD_LAT, MUL_LAT).
  - Each advancing edge (run=1) decrements every nonzero counter.
  - On issue of a writer, cnt[rd] := L.
  - Issue and decrement are simultaneous: the issued register loads L and is not decremented.
- RAW hazard: a read source s with cnt[s] != 0.
  - Result: a dependent instruction issues at the earliest LAT+1 edges after its producer.
  - Back-to-back dependency with LAT=4 gives exactly 4 bubble cycles.
- WAW hazard: a writer with cnt[rd] >= L. This keeps the later writer's writeback strictly after the earlier one.
- WB collision: reservation vector wb[M:0], where M = max latency + 1.
  - Bit i set means a write retires i advancing edges from now.
  - The vector shifts down by one each advancing edge.
  - Issuing a writer sets bit L after the shift.
  - Hazard if wb[L+1] is already set before the shift.
  - The execute stage drops writes when both pipes retire at once, so this collision check is mandatory.
- stall = in_valid & (RAW | WAW | WB) & run.
- Issue on a rising edge with run=1:
  - stall=0: out_* <= in_*, scoreboard and wb updated.
  - stall=1: out_* <= 0 (NOP bubble), no scoreboard load, stall_cnt += 1, saturating at all-ones.
- run=0: all state frozen (counters, wb, out_*, stall_cnt); fetch_en=0.
- fetch_en = rst & run & ~stall. Fetch holds its instruction while fetch_en=0, so in_* stays stable across a stall.
- Latency: one edge from in_* to out_* when not stalled.
- Throughput: one instruction per cycle when no hazards.

Test Plan:
1. ADD r3=r1+r2, then ADD r4=r3+r1 back-to-back -> second instruction on out_* exactly 5 edges after the first, 4 NOP bubbles in between, stall_cnt=4, fetch_en low 4 cycles.
2. Eight independent ADD/ADDI/MUL with distinct rd and equal latencies -> one issue per edge, stall never high, stall_cnt=0.
3. MUL r7 pending, then ADDI r6=r1+imm with imm[4:0]=7 (the rs2 bits equal 7) -> no stall. Then ADD r6=r1+r7 -> stalls until cnt[7]=0.
4. ADD with rd=0, then ADD reading r0 -> no stall. A writer to r0 leaves all counters 0.
5. MUL_LAT=5, ADD_LAT=4: MUL r8, then independent ADD r9 next cycle -> ADD held exactly 1 cycle (WB collision), issued on the following edge, stall_cnt=1.
6. Mid-stall (case 1, after 2 bubbles), pulse rst low -> out_*=0, stall_cnt=0 and fetch_en=0 immediately. After release, the re-presented dependent instruction issues with no stall. Separately, run=0 for 3 cycles mid-stall extends the bubble count by exactly 0, with state frozen.

Source files
------------

// File: rtl/issue_scoreboard.sv
// In-order issue stage: tracks in-flight register writes of the add and mult pipes
// and inserts NOP bubbles on RAW, write-order and writeback-port hazards.
`timescale 1ns/1ps
module issue_scoreboard #(
    parameter int ADD_LAT = 4,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             run,
    input  logic             in_valid,
    input  logic [2:0]       in_opcode,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic [11:0]      in_imm,
    output logic             fetch_en,
    output logic [2:0]       out_opcode,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [11:0]      out_imm,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int LW      = $clog2(MAX_LAT + 1);
    localparam int M       = MAX_LAT + 1;

    localparam logic [LW-1:0] ADD_L = LW'(ADD_LAT);
    localparam logic [LW-1:0] MUL_L = LW'(MUL_LAT);

    localparam logic [1:0] CLS_NOP  = 2'b00;
    localparam logic [1:0] CLS_ADD  = 2'b01;
    localparam logic [1:0] CLS_MUL  = 2'b10;

    logic [LW-1:0]    cnt_q [32];
    logic [LW-1:0]    cnt_d [32];
    logic [M:0]       wb_q, wb_d;
    logic [2:0]       opcode_q, opcode_d;
    logic [4:0]       rs1_q, rs1_d;
    logic [4:0]       rs2_q, rs2_d;
    logic [4:0]       rd_q, rd_d;
    logic [11:0]      imm_q, imm_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [1:0]    cls;
    logic          reads_rs1, reads_rs2, writes;
    logic [LW-1:0] lat;
    logic          raw_hit, waw_hit, wb_hit;

    // Decode: ADDI reads rs1 only because its rs2 field overlaps the immediate.
    always_comb begin
        cls       = in_opcode[1:0];
        reads_rs1 = in_valid && (cls != CLS_NOP);
        reads_rs2 = in_valid && ((cls == CLS_ADD) || (cls == CLS_MUL));
        writes    = in_valid && (cls != CLS_NOP) && (in_rd != 5'd0);
        lat       = (cls == CLS_MUL) ? MUL_L : ADD_L;
    end

    always_comb begin
        raw_hit = 1'b0;
        if (reads_rs1 && (in_rs1 != 5'd0) && (cnt_q[in_rs1] != '0)) raw_hit = 1'b1;
        if (reads_rs2 && (in_rs2 != 5'd0) && (cnt_q[in_rs2] != '0)) raw_hit = 1'b1;
        waw_hit = writes && (cnt_q[in_rd] >= lat);
        // A reservation at lat+1 would land on our slot once the vector shifts.
        wb_hit = 1'b0;
        for (int i = 0; i <= M; i++) begin
            if (writes && wb_q[i] && (i == int'(lat) + 1)) wb_hit = 1'b1;
        end
    end

    // Fetch handshake: fetch_en is the ready for the presented instruction; an
    // instruction (in_valid) is consumed on a rising edge only while fetch_en=1,
    // otherwise fetch must hold in_* stable until it is.
    assign stall    = in_valid && (raw_hit || waw_hit || wb_hit) && run;
    assign fetch_en = rst && run && !stall;

    always_comb begin
        for (int i = 0; i < 32; i++) cnt_d[i] = cnt_q[i];
        wb_d        = wb_q;
        opcode_d    = opcode_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        stall_cnt_d = stall_cnt_q;
        if (run) begin
            for (int i = 0; i < 32; i++) begin
                if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - LW'(1);
                if (!stall && writes && (in_rd == 5'(i))) cnt_d[i] = lat;
            end
            wb_d = wb_q >> 1;
            for (int i = 0; i <= M; i++) begin
                if (!stall && writes && (i == int'(lat))) wb_d[i] = 1'b1;
            end
            if (stall) begin
                opcode_d = '0;
                rs1_d    = '0;
                rs2_d    = '0;
                rd_d     = '0;
                imm_d    = '0;
                if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else begin
                opcode_d = in_opcode;
                rs1_d    = in_rs1;
                rs2_d    = in_rs2;
                rd_d     = in_rd;
                imm_d    = in_imm;
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
            wb_q        <= '0;
            opcode_q    <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
            wb_q        <= wb_d;
            opcode_q    <= opcode_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_opcode = opcode_q;
    assign out_rs1    = rs1_q;
    assign out_rs2    = rs2_q;
    assign out_rd     = rd_q;
    assign out_imm    = imm_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: an equal-latency instance and one with a
// slower multiplier (narrow stall counter) to reach writeback collisions and saturation.
`timescale 1ns/1ps
module tb_issue_scoreboard;

    logic        clock = 1'b0;
    logic        rst;
    logic        run;
    logic        in_valid;
    logic [2:0]  in_opcode;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [11:0] in_imm;

    logic        a_fetch_en, a_stall;
    logic [2:0]  a_opcode;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [11:0] a_imm;
    logic [15:0] a_stall_cnt;

    logic        b_fetch_en, b_stall;
    logic [2:0]  b_opcode;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [11:0] b_imm;
    logic [2:0]  b_stall_cnt;

    logic        sel;
    logic [29:0] obs_bundle;
    logic        obs_fetch_en, obs_stall;
    logic [15:0] obs_stall_cnt;

    logic [29:0] exp_q[$];
    int          issue_edges[$];
    int          edge_no = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    issue_scoreboard #(.ADD_LAT(4), .MUL_LAT(4), .CNT_W(16)) u_dut_a (
        .clock(clock), .rst(rst), .run(run), .in_valid(in_valid),
        .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .fetch_en(a_fetch_en), .out_opcode(a_opcode),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm),
        .stall(a_stall), .stall_cnt(a_stall_cnt)
    );

    issue_scoreboard #(.ADD_LAT(4), .MUL_LAT(5), .CNT_W(3)) u_dut_b (
        .clock(clock), .rst(rst), .run(run), .in_valid(in_valid),
        .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .fetch_en(b_fetch_en), .out_opcode(b_opcode),
        .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm),
        .stall(b_stall), .stall_cnt(b_stall_cnt)
    );

    assign obs_bundle    = sel ? {b_opcode, b_rs1, b_rs2, b_rd, b_imm}
                               : {a_opcode, a_rs1, a_rs2, a_rd, a_imm};
    assign obs_fetch_en  = sel ? b_fetch_en : a_fetch_en;
    assign obs_stall     = sel ? b_stall : a_stall;
    assign obs_stall_cnt = sel ? {13'd0, b_stall_cnt} : a_stall_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard side: every non-bubble bundle leaving the DUT pops the oldest expectation.
    initial begin
        logic        adv;
        logic [29:0] e;
        forever begin
            @(posedge clock);
            adv = run && rst;
            #1;
            if (adv) begin
                edge_no++;
                if (obs_bundle != 30'd0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_issue", 32'(obs_bundle), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("issue_bundle", 32'(obs_bundle), 32'(e));
                        issue_edges.push_back(edge_no);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_opcode = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        in_imm    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        @(negedge clock);
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
    endtask

    // Presents one instruction at a negedge and holds it until accepted; returns at
    // the negedge after the accepting edge with the inputs idled.
    task automatic issue(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [11:0] imm, input int exp_stalls,
                         input int pause_at, input string tag);
        int          stalls = 0;
        int          lows   = 0;
        int          guard  = 0;
        int          pause  = pause_at;
        logic [15:0] frozen;
        in_valid  = 1'b1;
        in_opcode = op;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_rd     = rd;
        in_imm    = imm;
        exp_q.push_back({op, rs1, rs2, rd, imm});
        #1;
        while (!obs_fetch_en) begin
            if (guard >= 60) begin
                n_vec++;
                n_err++;
                $error("FAIL timeout_%s: fetch_en low for %0d cycles, required at most %0d", tag, guard, exp_stalls);
                break;
            end
            if (obs_stall) stalls++;
            lows++;
            @(negedge clock);
            guard++;
            if (pause > 0 && stalls == pause) begin
                pause  = -1;
                frozen = obs_stall_cnt;
                run    = 1'b0;
                repeat (3) begin
                    #1;
                    check({tag, "_pause_stall"}, 32'(obs_stall), 32'd0);
                    check({tag, "_pause_fetch_en"}, 32'(obs_fetch_en), 32'd0);
                    check({tag, "_pause_stall_cnt"}, 32'(obs_stall_cnt), 32'(frozen));
                    check({tag, "_pause_out"}, 32'(obs_bundle), 32'd0);
                    @(negedge clock);
                end
                run = 1'b1;
            end
            #1;
        end
        @(negedge clock);
        idle_inputs();
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        check({tag, "_fetch_low"}, 32'(lows), 32'(exp_stalls));
    endtask

    function automatic int last_gap();
        int n;
        n = issue_edges.size();
        return (n < 2) ? -1 : issue_edges[n-1] - issue_edges[n-2];
    endfunction

    initial begin
        logic [1:0] cls;
        logic [2:0] op;
        int         first_edge;
        sel = 1'b0;
        run = 1'b1;
        rst = 1'b0;
        idle_inputs();
        #1;
        check("reset_out", 32'(obs_bundle), 32'd0);
        check("reset_stall_cnt", 32'(obs_stall_cnt), 32'd0);
        check("reset_fetch_en", 32'(obs_fetch_en), 32'd0);
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        #1;
        check("idle_fetch_en", 32'(obs_fetch_en), 32'd1);

        // Back-to-back RAW: four bubbles, issue 5 edges after the producer.
        issue(3'b001, 5'd1, 5'd2, 5'd3, 12'h0a5, 0, -1, "t1_prod");
        issue(3'b001, 5'd3, 5'd1, 5'd4, 12'h05a, 4, -1, "t1_dep");
        check("t1_stall_cnt", 32'(obs_stall_cnt), 32'd4);
        check("t1_gap", 32'(last_gap()), 32'd5);

        // Independent stream: one issue per edge.
        do_reset();
        first_edge = edge_no;
        for (int k = 0; k < 8; k++) begin
            cls = 2'(1 + (k % 3));
            op  = {1'($urandom_range(0, 1)), cls};
            issue(op, 5'($urandom_range(16, 31)), 5'($urandom_range(16, 31)), 5'(k + 1),
                  12'($urandom_range(0, 4095)), 0, -1, "t2");
        end
        check("t2_stall_cnt", 32'(obs_stall_cnt), 32'd0);
        check("t2_span", 32'(issue_edges[issue_edges.size()-1] - issue_edges[issue_edges.size()-8]), 32'd7);
        check("t2_first", 32'(issue_edges[issue_edges.size()-8] - first_edge), 32'd1);

        // ADDI ignores rs2; the ADD that really reads r7 waits out the MUL.
        do_reset();
        issue(3'b010, 5'd1, 5'd2, 5'd7, 12'h001, 0, -1, "t3_mul");
        issue(3'b011, 5'd1, 5'd7, 5'd6, 12'h007, 0, -1, "t3_addi");
        issue(3'b001, 5'd1, 5'd7, 5'd6, 12'h002, 3, -1, "t3_add");
        check("t3_stall_cnt", 32'(obs_stall_cnt), 32'd3);
        check("t3_gap", 32'(last_gap()), 32'd4);

        // R0 never hazards as source or destination.
        do_reset();
        issue(3'b001, 5'd1, 5'd2, 5'd0, 12'h011, 0, -1, "t4_w0");
        issue(3'b001, 5'd0, 5'd0, 5'd5, 12'h012, 0, -1, "t4_r0");
        issue(3'b010, 5'd0, 5'd0, 5'd0, 12'h013, 0, -1, "t4_mw0");
        check("t4_stall_cnt", 32'(obs_stall_cnt), 32'd0);

        // WAW with equal latency: second writer waits until cnt drops below L.
        do_reset();
        issue(3'b001, 5'd1, 5'd2, 5'd5, 12'h021, 0, -1, "t7_w1");
        issue(3'b001, 5'd1, 5'd2, 5'd5, 12'h022, 1, -1, "t7_w2");
        check("t7_stall_cnt", 32'(obs_stall_cnt), 32'd1);

        // Reset in the middle of a RAW stall.
        do_reset();
        issue(3'b001, 5'd1, 5'd2, 5'd3, 12'h031, 0, -1, "t6_prod");
        in_valid  = 1'b1;
        in_opcode = 3'b001;
        in_rs1    = 5'd3;
        in_rs2    = 5'd1;
        in_rd     = 5'd4;
        in_imm    = 12'h032;
        #1;
        check("t6_stall_high", 32'(obs_stall), 32'd1);
        @(negedge clock);
        @(negedge clock);
        #1;
        check("t6_two_bubbles", 32'(obs_stall_cnt), 32'd2);
        rst = 1'b0;
        #1;
        check("t6_rst_out", 32'(obs_bundle), 32'd0);
        check("t6_rst_stall_cnt", 32'(obs_stall_cnt), 32'd0);
        check("t6_rst_fetch_en", 32'(obs_fetch_en), 32'd0);
        @(negedge clock);
        rst = 1'b1;
        issue(3'b001, 5'd3, 5'd1, 5'd4, 12'h032, 0, -1, "t6_retry");
        check("t6_retry_stall_cnt", 32'(obs_stall_cnt), 32'd0);

        // run=0 in the middle of a stall freezes everything and adds no bubbles.
        do_reset();
        issue(3'b001, 5'd1, 5'd2, 5'd3, 12'h041, 0, -1, "t6b_prod");
        issue(3'b001, 5'd3, 5'd1, 5'd4, 12'h042, 4, 1, "t6b_dep");
        check("t6b_stall_cnt", 32'(obs_stall_cnt), 32'd4);

        // Slower multiplier: writeback collision holds the ADD exactly one cycle.
        sel = 1'b1;
        do_reset();
        issue(3'b010, 5'd1, 5'd2, 5'd8, 12'h051, 0, -1, "t5_mul");
        issue(3'b001, 5'd1, 5'd2, 5'd9, 12'h052, 1, -1, "t5_add");
        check("t5_stall_cnt", 32'(obs_stall_cnt), 32'd1);
        check("t5_gap", 32'(last_gap()), 32'd2);

        // Narrow counter saturates at all-ones (1 + 4 + 4 bubbles > 7).
        issue(3'b001, 5'd1, 5'd2, 5'd10, 12'h061, 0, -1, "t8_a");
        issue(3'b001, 5'd10, 5'd1, 5'd11, 12'h062, 4, -1, "t8_b");
        check("t8_cnt_5", 32'(obs_stall_cnt), 32'd5);
        issue(3'b001, 5'd11, 5'd1, 5'd12, 12'h063, 4, -1, "t8_c");
        check("t8_saturated", 32'(obs_stall_cnt), 32'd7);

        repeat (6) @(negedge clock);
        check("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
